// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory programmer fed by a byte stream.
// Accepts a 4-byte little-endian word-count header, then N little-endian data words.
// Each word becomes a single write pulse. The core is held in reset until a load
// finishes cleanly. Define IMEM_LOADER_CSUM_EN to require an XOR trailer byte after the data.

module imem_loader #(
  parameter int REG_SIZE       = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
  parameter int BASE_ADDR      = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  output logic                we_o,
  output logic [REG_SIZE-1:0] waddr_o,
  output logic [REG_SIZE-1:0] wdata_o,
  output logic                core_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  // The word index can reach NO_OF_REGS itself, so it needs one bit more than clog2.
  localparam int IDXW = $clog2(NO_OF_REGS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_FIN,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [REG_SIZE-1:0] asm_q, asm_d;
  logic [IDXW-1:0]     n_q, n_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                we_q, we_d;
  logic [REG_SIZE-1:0] waddr_q, waddr_d;
  logic [REG_SIZE-1:0] wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept;
  logic [REG_SIZE-1:0] asm_next;
  logic [IDXW-1:0]     idx_inc;

  // The byte handshake only opens while a load is collecting header, data or trailer.
  assign rx_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign busy_o     = rx_ready_o;
  assign accept     = rx_valid_i && rx_ready_o;
  // New bytes enter at the top so after four shifts the first byte sits in bits [7:0].
  assign asm_next   = {rx_data_i, asm_q[REG_SIZE-1:8]};
  assign idx_inc    = idx_q + 1'b1;

  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign core_rst_o = core_rst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  // State and datapath registers; reset aborts any load in flight, including a pending write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      asm_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state logic: header parse, word assembly, write issue and completion status.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_HDR;
          cnt_d      = '0;
          idx_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          core_rst_d = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end

      S_HDR: begin
        if (accept) begin
          asm_d = asm_next;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (asm_next == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end else if (asm_next > REG_SIZE'(NO_OF_REGS)) begin
              // Oversize counts are rejected before any write reaches memory.
              state_d = S_ERR;
            end else begin
              n_d     = asm_next[IDXW-1:0];
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          asm_d = asm_next;
          cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data_i;
`endif
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = REG_SIZE'(BASE_ADDR)
                    + {{(REG_SIZE-IDXW-2){1'b0}}, idx_q, 2'b00};
            wdata_d = asm_next;
            idx_d   = idx_inc;
            if (idx_inc == n_q) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data_i == csum_q) ? S_FIN : S_ERR;
        end
      end
`endif

      S_FIN: begin
        done_d     = 1'b1;
        core_rst_d = 1'b0;
        state_d    = S_IDLE;
      end

      S_ERR: begin
        // Words already written stay in memory, but the core is kept in reset.
        err_d      = 1'b1;
        core_rst_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected writes go into a queue as words are sent and are
// popped by a write monitor; each scenario task checks status levels itself.
module tb_imem_loader;

  localparam int NREGS = 256;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int          total  = 0;
  int          bad    = 0;
  int          we_cnt = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_e;
  logic [31:0] wbuf[$];

  imem_loader dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .core_rst_o (core_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Write monitor: every write pulse must match the oldest expected write.
  always @(negedge clk_i) begin
    if (!rst_i && we_o) begin
      we_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got addr=%h data=%h, required no write", waddr_o, wdata_o);
      end else begin
        mon_e = sb.pop_front();
        if ({waddr_o, wdata_o} !== mon_e) begin
          bad++;
          $display("FAIL write_value got addr=%h data=%h, required addr=%h data=%h",
                   waddr_o, wdata_o, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int w = 0; w < 50 && !rx_ready_o; w++) @(negedge clk_i);
    if (!rx_ready_o) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout got ready=0 for 50 cycles, required ready=1");
    end else begin
      @(negedge clk_i);
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Send header n, then wbuf[0..n-1] with random gaps, then the trailer when compiled in.
  task automatic run_load(input logic [31:0] n, input int maxgap, input bit bad_csum,
                          input bit poke_start);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], $urandom_range(0, maxgap));
    if (n <= NREGS) begin
      for (int i = 0; i < int'(n); i++) begin
        w = wbuf[i];
        sb.push_back({32'(4 * i), w});
        if (poke_start && i == 1) pulse_start();
        for (int b = 0; b < 4; b++) begin
          cs = cs ^ w[8*b +: 8];
          send_byte(w[8*b +: 8], $urandom_range(0, maxgap));
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, $urandom_range(0, maxgap));
`endif
    end
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    while (!(done_o || err_o) && c < 200) begin
      @(negedge clk_i);
      c++;
    end
    if (!(done_o || err_o)) begin
      total++;
      bad++;
      $display("FAIL load_end_timeout got done=0 err=0, required one of them set");
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    int base;
    bit rst_dropped;
    rst_i = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    total += 8;
    if (rx_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got %b required 0", rx_ready_o); end
    if (we_o !== 1'b0) begin bad++; $display("FAIL rst_we got %b required 0", we_o); end
    if (waddr_o !== 32'h0) begin bad++; $display("FAIL rst_waddr got %h required 0", waddr_o); end
    if (wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata got %h required 0", wdata_o); end
    if (core_rst_o !== 1'b1) begin bad++; $display("FAIL rst_core_rst got %b required 1", core_rst_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got %b required 0", done_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got %b required 0", err_o); end
    base = we_cnt;
    rst_dropped = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hA5;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (core_rst_o !== 1'b1 || rx_ready_o !== 1'b0) rst_dropped = 1'b1;
    end
    rx_valid_i = 1'b0;
    total += 2;
    if (rst_dropped) begin bad++; $display("FAIL idle_hold got core_rst/ready changed, required 1/0 for 100 cycles"); end
    if (we_cnt - base != 0) begin bad++; $display("FAIL idle_writes got %0d required 0", we_cnt - base); end
  endtask

  task automatic test_basic();
    int base;
    base = we_cnt;
    wbuf = {32'h00000013, 32'h00100093};
    run_load(32'd2, 0, 1'b0, 1'b0);
    wait_end();
    total += 7;
    if (done_o !== 1'b1) begin bad++; $display("FAIL basic_done got %b required 1", done_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL basic_err got %b required 0", err_o); end
    if (core_rst_o !== 1'b0) begin bad++; $display("FAIL basic_core_rst got %b required 0", core_rst_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy got %b required 0", busy_o); end
    if (we_cnt - base != 2) begin bad++; $display("FAIL basic_writes got %0d required 2", we_cnt - base); end
    if (sb.size() != 0) begin bad++; $display("FAIL basic_missing got %0d pending required 0", sb.size()); end
    if (waddr_o !== 32'h4 || wdata_o !== 32'h00100093) begin
      bad++; $display("FAIL basic_hold got %h/%h required 00000004/00100093", waddr_o, wdata_o);
    end
  endtask

  task automatic test_oversize();
    int base;
    base = we_cnt;
    run_load(32'(NREGS + 1), 0, 1'b0, 1'b0);
    wait_end();
    total += 5;
    if (err_o !== 1'b1) begin bad++; $display("FAIL over_err got %b required 1", err_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL over_done got %b required 0", done_o); end
    if (core_rst_o !== 1'b1) begin bad++; $display("FAIL over_core_rst got %b required 1", core_rst_o); end
    if (rx_ready_o !== 1'b0) begin bad++; $display("FAIL over_ready got %b required 0", rx_ready_o); end
    if (we_cnt - base != 0) begin bad++; $display("FAIL over_writes got %0d required 0", we_cnt - base); end
  endtask

  task automatic test_zero();
    int base;
    base = we_cnt;
    run_load(32'd0, 0, 1'b0, 1'b0);
    wait_end();
    total += 3;
    if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done got %b required 1", done_o); end
    if (core_rst_o !== 1'b0) begin bad++; $display("FAIL zero_core_rst got %b required 0", core_rst_o); end
    if (we_cnt - base != 0) begin bad++; $display("FAIL zero_writes got %0d required 0", we_cnt - base); end
  endtask

  task automatic test_gaps();
    int base;
    wbuf = {};
    for (int i = 0; i < 5; i++) wbuf.push_back($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      base = we_cnt;
      run_load(32'd5, pass == 0 ? 0 : 5, 1'b0, 1'b0);
      wait_end();
      total += 3;
      if (done_o !== 1'b1) begin bad++; $display("FAIL gaps_done pass=%0d got %b required 1", pass, done_o); end
      if (we_cnt - base != 5) begin bad++; $display("FAIL gaps_writes pass=%0d got %0d required 5", pass, we_cnt - base); end
      if (sb.size() != 0) begin bad++; $display("FAIL gaps_missing pass=%0d got %0d required 0", pass, sb.size()); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [31:0] w0;
    base = we_cnt;
    w0 = 32'hCAFE0001;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 2 : 0), 0);
    // The first complete word is a genuine write before reset hits.
    sb.push_back({32'h0, w0});
    for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    total += 2;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b required 0", busy_o); end
    if (core_rst_o !== 1'b1) begin bad++; $display("FAIL mid_rst_core got %b required 1", core_rst_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    wbuf = {32'h12345678};
    run_load(32'd1, 2, 1'b0, 1'b0);
    wait_end();
    total += 3;
    if (done_o !== 1'b1) begin bad++; $display("FAIL mid_done got %b required 1", done_o); end
    if (we_cnt - base != 2) begin bad++; $display("FAIL mid_writes got %0d required 2", we_cnt - base); end
    if (sb.size() != 0) begin bad++; $display("FAIL mid_missing got %0d required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = we_cnt;
    wbuf = {32'h0000006F, 32'hDEADBEEF, 32'h80000000};
    run_load(32'd3, 0, 1'b0, 1'b1);
    wait_end();
    total += 3;
    if (done_o !== 1'b1) begin bad++; $display("FAIL b2b_done got %b required 1", done_o); end
    if (we_cnt - base != 3) begin bad++; $display("FAIL b2b_writes got %0d required 3", we_cnt - base); end
    if (sb.size() != 0) begin bad++; $display("FAIL b2b_missing got %0d required 0", sb.size()); end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_csum_bad();
    int base;
    base = we_cnt;
    wbuf = {32'h00000013, 32'h00100093};
    run_load(32'd2, 0, 1'b1, 1'b0);
    wait_end();
    total += 4;
    if (err_o !== 1'b1) begin bad++; $display("FAIL csum_err got %b required 1", err_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL csum_done got %b required 0", done_o); end
    if (core_rst_o !== 1'b1) begin bad++; $display("FAIL csum_core_rst got %b required 1", core_rst_o); end
    if (we_cnt - base != 2) begin bad++; $display("FAIL csum_writes got %0d required 2", we_cnt - base); end
  endtask
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_oversize();
    test_zero();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef IMEM_LOADER_CSUM_EN
    test_csum_bad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
